// File: rtl/axis_pixel_capture_if.sv
// Stream-in and record-out bundles for axis_pixel_capture.
interface axis_pix_if #(parameter int DATA_W = 24);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

interface pix_rec_if #(
  parameter int X_W     = 12,
  parameter int Y_W     = 12,
  parameter int FRAME_W = 16,
  parameter int DATA_W  = 24
);
  logic               valid;
  logic               ready;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [FRAME_W-1:0] frame;
  logic [DATA_W-1:0]  data;

  modport master (output valid, x, y, frame, data, input ready);
  modport slave  (input valid, x, y, frame, data, output ready);
endinterface

// File: rtl/axis_pixel_capture.sv
// AXI4-Stream pixel sink: tags beats with (x, y, frame), checks geometry, queues records.
// Optional macro PIX_CHECKSUM_EN adds a per-frame byte-sum checksum on frame_checksum.
module axis_pixel_capture #(
  parameter int DATA_W     = 24,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int X_W        = 12,
  parameter int Y_W        = 12,
  parameter int FRAME_W    = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  axis_pix_if.slave   s_axis,
  pix_rec_if.master   rec,
  output logic        frame_done,
  output logic        err_early_eol,
  output logic        err_late_eol,
  output logic        err_sof_mid,
  input  logic        err_clr,
  output logic [31:0] frame_checksum
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [FRAME_W-1:0] frame;
    logic [DATA_W-1:0]  data;
  } rec_t;

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t             r_state, w_state_nxt;
  logic [X_W-1:0]     r_x, w_x_nxt, w_px;
  logic [Y_W-1:0]     r_y, w_y_nxt, w_py;
  logic [FRAME_W-1:0] r_frame, w_frame_nxt, w_pf;
  logic               w_acc, w_push, w_sof_mid, w_early, w_late, w_fdone, w_line_end;

  logic               r_tready;
  logic               r_frame_done, r_err_early, r_err_late, r_err_sof;

  rec_t               r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr, r_rd;
  logic [AW:0]        r_cnt, w_cnt_nxt;
  logic               w_pop, w_nempty;
  rec_t               w_rec, w_head;

  assign w_acc         = s_axis.tvalid & r_tready;
  assign s_axis.tready = r_tready;

  // The accepted beat is first resolved to its pixel position (w_px/w_py/w_pf);
  // SOF beats from either state collapse to (0,0), then one line-end rule applies.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_frame_nxt = r_frame;
    w_px        = r_x;
    w_py        = r_y;
    w_pf        = r_frame;
    w_push      = 1'b0;
    w_sof_mid   = 1'b0;
    w_early     = 1'b0;
    w_late      = 1'b0;
    w_fdone     = 1'b0;
    w_line_end  = 1'b0;
    if (w_acc) begin
      case (r_state)
        WAIT_SOF: begin
          if (s_axis.tuser) begin
            w_push = 1'b1;
            w_px   = '0;
            w_py   = '0;
          end
        end
        default: begin
          w_push = 1'b1;
          if (s_axis.tuser && (r_x != '0 || r_y != '0)) begin
            w_sof_mid = 1'b1;
            w_px      = '0;
            w_py      = '0;
            w_pf      = r_frame + 1'b1;
          end
        end
      endcase
      if (w_push) begin
        w_line_end  = s_axis.tlast | (w_px == X_LAST);
        w_early     = s_axis.tlast & (w_px != X_LAST);
        w_late      = ~s_axis.tlast & (w_px == X_LAST);
        w_frame_nxt = w_pf;
        w_state_nxt = ACTIVE;
        if (w_line_end) begin
          w_x_nxt = '0;
          if (w_py == Y_LAST) begin
            w_y_nxt     = '0;
            w_frame_nxt = w_pf + 1'b1;
            w_fdone     = 1'b1;
            w_state_nxt = WAIT_SOF;
          end else begin
            w_y_nxt = w_py + 1'b1;
          end
        end else begin
          w_x_nxt = w_px + 1'b1;
          w_y_nxt = w_py;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= WAIT_SOF;
      r_x          <= '0;
      r_y          <= '0;
      r_frame      <= '0;
      r_frame_done <= 1'b0;
      r_err_early  <= 1'b0;
      r_err_late   <= 1'b0;
      r_err_sof    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_frame      <= w_frame_nxt;
      r_frame_done <= w_fdone;
      r_err_early  <= err_clr ? 1'b0 : (r_err_early | w_early);
      r_err_late   <= err_clr ? 1'b0 : (r_err_late  | w_late);
      r_err_sof    <= err_clr ? 1'b0 : (r_err_sof   | w_sof_mid);
    end
  end

  assign frame_done    = r_frame_done;
  assign err_early_eol = r_err_early;
  assign err_late_eol  = r_err_late;
  assign err_sof_mid   = r_err_sof;

  // Record FIFO. tready is registered from the next occupancy and is held low
  // whenever full, in both states, so an SOF can never overrun a full FIFO.
  assign w_rec     = '{x: w_px, y: w_py, frame: w_pf, data: s_axis.tdata};
  assign w_nempty  = (r_cnt != '0);
  assign w_pop     = w_nempty & rec.ready;
  assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_rec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_tready <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt    <= w_cnt_nxt;
      r_tready <= (w_cnt_nxt != CNT_FULL);
    end
  end

  assign w_head    = w_nempty ? r_mem[r_rd] : '0;
  assign rec.valid = w_nempty;
  assign rec.x     = w_head.x;
  assign rec.y     = w_head.y;
  assign rec.frame = w_head.frame;
  assign rec.data  = w_head.data;

`ifdef PIX_CHECKSUM_EN
  logic [31:0] r_acc, r_chk, w_bsum, w_base;
  logic        w_sof;

  always_comb begin
    w_bsum = '0;
    for (int i = 0; i < DATA_W/8; i++) w_bsum = w_bsum + 32'(s_axis.tdata[i*8 +: 8]);
  end

  // Any SOF pixel (fresh or mid-frame restart) starts the sum from its own bytes.
  assign w_sof  = w_push & ((r_state == WAIT_SOF) | w_sof_mid);
  assign w_base = w_sof ? 32'd0 : r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_chk <= '0;
    end else if (w_push) begin
      if (w_fdone) begin
        r_chk <= w_base + w_bsum;
        r_acc <= '0;
      end else begin
        r_acc <= w_base + w_bsum;
      end
    end
  end

  assign frame_checksum = r_chk;
`else
  assign frame_checksum = 32'd0;
`endif

endmodule

// File: tb/tb_axis_pixel_capture.sv
// Directed bench for axis_pixel_capture with a 4x2 image and 16-deep record FIFO.
module tb_axis_pixel_capture;
  logic        clk = 1'b0;
  logic        rst;
  logic        err_clr;
  logic        frame_done, err_early_eol, err_late_eol, err_sof_mid;
  logic [31:0] frame_checksum;

  axis_pix_if #(.DATA_W(24)) s_if ();
  pix_rec_if  #(.X_W(12), .Y_W(12), .FRAME_W(16), .DATA_W(24)) r_if ();

  axis_pixel_capture #(
    .DATA_W(24), .IMG_W(4), .IMG_H(2), .X_W(12), .Y_W(12), .FRAME_W(16), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .s_axis(s_if), .rec(r_if),
    .frame_done(frame_done), .err_early_eol(err_early_eol), .err_late_eol(err_late_eol),
    .err_sof_mid(err_sof_mid), .err_clr(err_clr), .frame_checksum(frame_checksum)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          fd_cnt = 0;
  logic [63:0] q [$];

  // Records are captured on the falling edge; the pop happens on the next rising edge.
  always @(negedge clk) begin
    if (r_if.valid && r_if.ready) q.push_back({r_if.x, r_if.y, r_if.frame, r_if.data});
    if (frame_done) fd_cnt++;
  end

  function automatic logic [63:0] mk(int x, int y, int f, int d);
    return {12'(x), 12'(y), 16'(f), 24'(d)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic beat(int d, logic u, logic l);
    int n = 0;
    s_if.tdata = 24'(d); s_if.tuser = u; s_if.tlast = l; s_if.tvalid = 1'b1;
    while (!s_if.tready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) chk("beat_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
  endtask

  task automatic idle(int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  initial begin
    int   n;
    logic w;
    rst = 1'b1; err_clr = 1'b0; r_if.ready = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
    idle(3);
    chk("rst_tready", 64'(s_if.tready), 64'd0);
    chk("rst_valid",  64'(r_if.valid), 64'd0);
    rst = 1'b0;
    idle(1);
    chk("post_rst_tready", 64'(s_if.tready), 64'd1);
    chk("post_rst_errs", 64'({err_early_eol, err_late_eol, err_sof_mid, frame_done}), 64'd0);
    chk("post_rst_chk", 64'(frame_checksum), 64'd0);

    // Clean frame 0
    for (int i = 0; i < 8; i++) beat(i + 1, i == 0, (i % 4) == 3);
    idle(3);
    chk("t1_count", 64'(q.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk("t1_rec", q[i], mk(i % 4, i / 4, 0, i + 1));
    chk("t1_fd", 64'(fd_cnt), 64'd1);
    chk("t1_errs", 64'({err_early_eol, err_late_eol, err_sof_mid}), 64'd0);
`ifdef PIX_CHECKSUM_EN
    chk("t1_chk", 64'(frame_checksum), 64'd36);
`else
    chk("t1_chk", 64'(frame_checksum), 64'd0);
`endif

    // Pre-SOF beats are dropped; frame 1
    q.delete();
    for (int i = 0; i < 3; i++) beat(32'h99 + i, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) beat(32'h11 + i, i == 0, (i % 4) == 3);
    idle(3);
    chk("t2_count", 64'(q.size()), 64'd8);
    chk("t2_first", q[0], mk(0, 0, 1, 32'h11));
    chk("t2_last",  q[7], mk(3, 1, 1, 32'h18));
    chk("t2_fd", 64'(fd_cnt), 64'd2);
`ifdef PIX_CHECKSUM_EN
    chk("t2_chk", 64'(frame_checksum), 64'd164);
`endif

    // Early EOL in frame 2, then err_clr
    q.delete();
    beat(32'h21, 1'b1, 1'b0);
    beat(32'h22, 1'b0, 1'b1);
    chk("t3_early_set", 64'(err_early_eol), 64'd1);
    beat(32'h23, 1'b0, 1'b0);
    idle(2);
    chk("t3_next_rec", q[2], mk(0, 1, 2, 32'h23));
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("t3_early_clr", 64'(err_early_eol), 64'd0);
    beat(32'h24, 1'b0, 1'b0);
    beat(32'h25, 1'b0, 1'b0);
    beat(32'h26, 1'b0, 1'b1);
    idle(3);
    chk("t3_fd", 64'(fd_cnt), 64'd3);
    chk("t3_no_late", 64'(err_late_eol), 64'd0);

    // SOF mid-frame on beat 5 of frame 3; frame 4 then has a late EOL
    q.delete();
    for (int i = 0; i < 4; i++) beat(32'h31 + i, i == 0, i == 3);
    beat(32'h35, 1'b1, 1'b0);
    chk("t4_sof_mid", 64'(err_sof_mid), 64'd1);
    beat(32'h36, 1'b0, 1'b0);
    beat(32'h37, 1'b0, 1'b0);
    beat(32'h38, 1'b0, 1'b0);
    chk("t4_late", 64'(err_late_eol), 64'd1);
    chk("t4_fd_none", 64'(fd_cnt), 64'd3);
    for (int i = 0; i < 4; i++) beat(32'h39 + i, 1'b0, i == 3);
    idle(3);
    chk("t4_count", 64'(q.size()), 64'd12);
    chk("t4_rec5",  q[4],  mk(0, 0, 4, 32'h35));
    chk("t4_rec8",  q[7],  mk(3, 0, 4, 32'h38));
    chk("t4_rec12", q[11], mk(3, 1, 4, 32'h3C));
    chk("t4_fd", 64'(fd_cnt), 64'd4);
`ifdef PIX_CHECKSUM_EN
    chk("t4_chk", 64'(frame_checksum), 64'd452);
`endif
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("t4_clr_all", 64'({err_early_eol, err_late_eol, err_sof_mid}), 64'd0);

    // Back-pressure: FIFO fills with 16 records (frames 5 and 6) then drains in order
    q.delete();
    r_if.ready = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 24'(32'h40 + n);
      s_if.tuser  = (n % 8) == 0;
      s_if.tlast  = (n % 4) == 3;
      w = s_if.tready;
      @(posedge clk);
      if (w) n++;
      #1;
    end
    chk("t5_accepted", 64'(n), 64'd16);
    chk("t5_tready_low", 64'(s_if.tready), 64'd0);
    chk("t5_no_pop", 64'(q.size()), 64'd0);
    s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
    r_if.ready = 1'b1;
    idle(20);
    chk("t5_count", 64'(q.size()), 64'd16);
    chk("t5_rec0",  q[0],  mk(0, 0, 5, 32'h40));
    chk("t5_rec8",  q[8],  mk(0, 0, 6, 32'h48));
    chk("t5_rec15", q[15], mk(3, 1, 6, 32'h4F));
    chk("t5_tready_back", 64'(s_if.tready), 64'd1);
    chk("t5_fd", 64'(fd_cnt), 64'd6);
`ifdef PIX_CHECKSUM_EN
    chk("t5_chk", 64'(frame_checksum), 64'd604);
`endif

    // Reset after 3 beats of frame 7 with records still queued
    q.delete();
    r_if.ready = 1'b0;
    beat(32'h51, 1'b1, 1'b0);
    beat(32'h52, 1'b0, 1'b0);
    beat(32'h53, 1'b0, 1'b0);
    chk("t6_queued", 64'(r_if.valid), 64'd1);
    rst = 1'b1;
    #2;
    chk("t6_rst_valid", 64'(r_if.valid), 64'd0);
    chk("t6_rst_tready", 64'(s_if.tready), 64'd0);
    idle(1);
    rst = 1'b0;
    r_if.ready = 1'b1;
    idle(1);
    chk("t6_tready", 64'(s_if.tready), 64'd1);
    beat(32'h61, 1'b1, 1'b0);
    idle(3);
    chk("t6_count", 64'(q.size()), 64'd1);
    chk("t6_rec", q[0], mk(0, 0, 0, 32'h61));
    chk("t6_fd", 64'(fd_cnt), 64'd6);
    chk("t6_chk", 64'(frame_checksum), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
